// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the external bus sequencer: widths, FSM state
// encoding, the latched-transaction record and a saturating counter helper.
package bus_sequencer_pkg;

   localparam int BUS_AW   = 20;               // full address width
   localparam int BUS_DW   = 16;               // multiplexed address/data width
   localparam int HI_W     = BUS_AW - BUS_DW;  // upper address bits on a_hi
   localparam int WAIT_W   = 3;                // wait-state counter width
   localparam int STARVE_W = 4;                // starvation counter width

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_STRB = 3'd2,
      ST_END  = 3'd3,
      ST_TURN = 3'd4
   } state_e;

   // Fields captured from the winning requester when ADDR is entered
   typedef struct packed {
      logic              is_f;   // 1 = fetch port owns the transaction
      logic              wr;     // 1 = write
      logic              pio;    // 1 = I/O space
      logic [BUS_AW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
   } txn_t;

   localparam txn_t TXN_RESET = '{is_f:  1'b0,
                                  wr:    1'b0,
                                  pio:   1'b0,
                                  addr:  20'h0_0000,
                                  wdata: 16'h0000};

   // Increment that sticks at lim instead of wrapping
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                   input logic [STARVE_W-1:0] lim);
      if (v >= lim) begin
         sat_inc = lim;
      end else begin
         sat_inc = v + 4'd1;
      end
   endfunction

endpackage

// File: rtl/bus_sequencer_arb.sv
// Fetch/data arbiter. Data normally wins; a fetch that has watched
// STARVE_LIMIT consecutive data grants go by is forced through next.
module bus_sequencer_arb
   import bus_sequencer_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic f_req,
   input  logic d_req,
   input  logic arb_en,
   output logic gnt_d,
   output logic gnt_f
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_q;
   logic [STARVE_W-1:0] starve_d;

   // Grant decision and starvation bookkeeping for this arbitration slot
   always_comb begin
      gnt_f    = 1'b0;
      gnt_d    = 1'b0;
      starve_d = starve_q;
      if (arb_en) begin
         if (f_req && (!d_req || (starve_q == LIMIT))) begin
            gnt_f    = 1'b1;
            starve_d = {STARVE_W{1'b0}};
         end else if (d_req) begin
            gnt_d = 1'b1;
            if (f_req) begin
               starve_d = sat_inc(starve_q, LIMIT);
            end else begin
               starve_d = {STARVE_W{1'b0}};
            end
         end else begin
            starve_d = starve_q;
         end
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= {STARVE_W{1'b0}};
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/bus_sequencer.sv
// Sole master of the multiplexed external bus. Each transaction runs
// ADDR -> STRB (wait states, rdy stretch) -> END, with a TURN cycle after
// reads so the pads can release ad before the next address phase.
// Every pin-facing output comes straight from a flop; the output flops are
// loaded from the next state so they line up with the state register.
module bus_sequencer
   import bus_sequencer_pkg::*;
#(
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [BUS_AW-1:0] f_addr,
   output logic              f_ack,
   input  logic              d_req,
   input  logic [BUS_AW-1:0] d_addr,
   input  logic              d_we,
   input  logic              d_pio,
   input  logic [BUS_DW-1:0] d_wdata,
   output logic              d_ack,
   output logic [BUS_DW-1:0] rdata,
   input  logic              rdy,
   input  logic [BUS_DW-1:0] ad_in,
   output logic [BUS_DW-1:0] ad_out,
   output logic              ad_oe,
   output logic [HI_W-1:0]   a_hi,
   output logic              ale,
   output logic              oe,
   output logic              we,
   output logic              pio,
   output logic              busy
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   txn_t                txn_q, txn_d;
   logic [BUS_DW-1:0]   rdata_q, rdata_d;
   logic [BUS_DW-1:0]   ad_out_q, ad_out_d;
   logic [HI_W-1:0]     a_hi_q, a_hi_d;
   logic                ale_q, ale_d;
   logic                oe_q, oe_d;
   logic                we_q, we_d;
   logic                ad_oe_q, ad_oe_d;
   logic                pio_q, pio_d;
   logic                f_ack_q, f_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                busy_q, busy_d;

   logic                arb_en;
   logic                gnt_f;
   logic                gnt_d;

   // Arbitration slots: idle, after turnaround, and at the end of a write
   assign arb_en = (state_q == ST_IDLE) || (state_q == ST_TURN) ||
                   ((state_q == ST_END) && txn_q.wr);

   bus_sequencer_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .f_req  (f_req),
      .d_req  (d_req),
      .arb_en (arb_en),
      .gnt_d  (gnt_d),
      .gnt_f  (gnt_f)
   );

   // Next state, wait counter, read capture and grant-time field latch
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      txn_d   = txn_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (gnt_f || gnt_d) begin
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            state_d = ST_STRB;
            wcnt_d  = WAIT_INIT;
         end
         ST_STRB: begin
            if ((wcnt_q == WAIT_ZERO) && rdy) begin
               state_d = ST_END;
               if (!txn_q.wr) begin
                  rdata_d = ad_in;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (wcnt_q != WAIT_ZERO) begin
               wcnt_d = wcnt_q - WAIT_ONE;
            end else begin
               wcnt_d = wcnt_q;
            end
         end
         ST_END: begin
            if (!txn_q.wr) begin
               state_d = ST_TURN;
            end else if (gnt_f || gnt_d) begin
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Requester fields are frozen here; later changes on the ports are ignored
      if (gnt_f) begin
         txn_d.is_f  = 1'b1;
         txn_d.wr    = 1'b0;
         txn_d.pio   = 1'b0;
         txn_d.addr  = f_addr;
         txn_d.wdata = txn_q.wdata;
      end else if (gnt_d) begin
         txn_d.is_f  = 1'b0;
         txn_d.wr    = d_we;
         txn_d.pio   = d_pio;
         txn_d.addr  = d_addr;
         txn_d.wdata = d_wdata;
      end else begin
         txn_d = txn_q;
      end
   end

   // Pin values for the state being entered; strobes default inactive
   always_comb begin
      ale_d   = 1'b0;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      ad_oe_d = 1'b0;
      ad_out_d = ad_out_q;
      a_hi_d  = {HI_W{1'b0}};
      pio_d   = 1'b0;
      f_ack_d = 1'b0;
      d_ack_d = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      case (state_d)
         ST_ADDR: begin
            ale_d    = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = txn_d.addr[BUS_DW-1:0];
            a_hi_d   = txn_d.addr[BUS_AW-1:BUS_DW];
            pio_d    = txn_d.pio;
         end
         ST_STRB: begin
            a_hi_d = txn_d.addr[BUS_AW-1:BUS_DW];
            pio_d  = txn_d.pio;
            if (txn_d.wr) begin
               ad_out_d = txn_d.wdata;
               ad_oe_d  = 1'b1;
               we_d     = 1'b0;
            end else begin
               ad_oe_d = 1'b0;
               oe_d    = 1'b0;
            end
         end
         ST_END: begin
            // Writes keep driving ad for data hold; reads stay released
            a_hi_d  = txn_d.addr[BUS_AW-1:BUS_DW];
            pio_d   = txn_d.pio;
            ad_oe_d = txn_d.wr;
            f_ack_d = txn_d.is_f;
            d_ack_d = !txn_d.is_f;
         end
         default: begin
            ale_d = 1'b0;
         end
      endcase
   end

   // State, transaction and output registers; reset drops the bus at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= WAIT_ZERO;
         txn_q    <= TXN_RESET;
         rdata_q  <= 16'h0000;
         ad_out_q <= 16'h0000;
         a_hi_q   <= 4'h0;
         ale_q    <= 1'b0;
         oe_q     <= 1'b1;
         we_q     <= 1'b1;
         ad_oe_q  <= 1'b0;
         pio_q    <= 1'b0;
         f_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         txn_q    <= txn_d;
         rdata_q  <= rdata_d;
         ad_out_q <= ad_out_d;
         a_hi_q   <= a_hi_d;
         ale_q    <= ale_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         ad_oe_q  <= ad_oe_d;
         pio_q    <= pio_d;
         f_ack_q  <= f_ack_d;
         d_ack_q  <= d_ack_d;
         busy_q   <= busy_d;
      end
   end

   assign f_ack  = f_ack_q;
   assign d_ack  = d_ack_q;
   assign rdata  = rdata_q;
   assign ad_out = ad_out_q;
   assign ad_oe  = ad_oe_q;
   assign a_hi   = a_hi_q;
   assign ale    = ale_q;
   assign oe     = oe_q;
   assign we     = we_q;
   assign pio    = pio_q;
   assign busy   = busy_q;

endmodule
